// File: rtl/fifo_p_arb.sv
// fifo_p_arb: three-channel (8/16/32-bit) store-and-forward packet aggregator onto a 16-bit bus.
// Define FIFO_P_RR_EN for round-robin grants; the default build uses fixed priority A > B > C.

module fifo_p_arb_ch #(
  parameter int DW = 18,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld_i,
  input  logic          sop_i,
  input  logic          wr_req_i,
  input  logic          wr_eop_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic          pkt_done_i,
  output logic [DW-1:0] rd_data_o,
  output logic          pkt_avail_o
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, start_q, start_d, rd_ptr_q, base;
  logic [AW:0]   pkt_cnt_q;
  logic          in_pkt_q, in_pkt_d, active, full, do_wr, commit;

  // A sop inside an open packet writes from the saved start, dropping the partial packet.
  always_comb begin
    active   = vld_i & (sop_i | in_pkt_q);
    base     = (sop_i & in_pkt_q) ? start_q : wr_ptr_q;
    full     = (base - rd_ptr_q) == (AW+1)'(DEPTH);
    wr_ptr_d = wr_ptr_q;
    start_d  = start_q;
    in_pkt_d = in_pkt_q;
    do_wr    = 1'b0;
    commit   = 1'b0;
    if (active) begin
      if (sop_i) begin
        start_d  = base;
        wr_ptr_d = base;
        in_pkt_d = 1'b1;
      end
      if (wr_req_i) begin
        if (full) begin
          wr_ptr_d = start_d;
          in_pkt_d = 1'b0;
        end else begin
          do_wr    = 1'b1;
          wr_ptr_d = base + PTR_ONE;
          if (wr_eop_i) begin
            in_pkt_d = 1'b0;
            commit   = 1'b1;
          end
        end
      end
    end
  end

  assign rd_data_o   = mem_q[rd_ptr_q[AW-1:0]];
  assign pkt_avail_o = pkt_cnt_q > {{AW{1'b0}}, pkt_done_i};

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[base[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      start_q   <= '0;
      rd_ptr_q  <= '0;
      in_pkt_q  <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      start_q  <= start_d;
      in_pkt_q <= in_pkt_d;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({commit, pkt_done_i})
        2'b10:   pkt_cnt_q <= pkt_cnt_q + PTR_ONE;
        2'b01:   pkt_cnt_q <= pkt_cnt_q - PTR_ONE;
        default: pkt_cnt_q <= pkt_cnt_q;
      endcase
    end
  end
endmodule

module fifo_p_arb #(
  parameter int AW = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_a,
  input  logic        data_a_vld,
  input  logic        data_a_sop,
  input  logic        data_a_eop,
  input  logic [15:0] data_b,
  input  logic        data_b_vld,
  input  logic        data_b_sop,
  input  logic        data_b_eop,
  input  logic [1:0]  data_b_mty,
  input  logic [31:0] data_c,
  input  logic        data_c_vld,
  input  logic        data_c_sop,
  input  logic        data_c_eop,
  input  logic [1:0]  data_c_mty,
  output logic [15:0] data_d,
  output logic        data_d_vld,
  output logic        data_d_sop,
  output logic        data_d_eop,
  output logic        data_d_mty,
  output logic [1:0]  chan_d
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d, pick;
  logic        half_q, half_d, first_q, first_d;
  logic        a_odd_q, a_odd_d, a_odd_eff, a_wr_req;
  logic [7:0]  a_hold_q;
  logic [17:0] a_wr_data, b_wr_data, ent_a, ent_b;
  logic [34:0] c_wr_data, ent_c;
  logic [2:0]  rd_en, done, elig;
  logic        send, sel_eop, sel_mty, pkt_end, free;
  logic [15:0] sel_word;
  logic [15:0] out_data_q;
  logic        out_vld_q, out_sop_q, out_eop_q, out_mty_q;
  logic [1:0]  out_chan_q;
  logic        unused_b_mty;

  assign unused_b_mty = data_b_mty[1];

  // Channel A packer: a sop byte always lands in [15:8]; entries carry {eop, mty, data}.
  assign a_odd_eff = a_odd_q & ~data_a_sop;
  assign a_wr_req  = a_odd_eff | data_a_eop;
  assign a_odd_d   = ~a_odd_eff & ~data_a_eop;
  assign a_wr_data = a_odd_eff ? {data_a_eop, 1'b0, a_hold_q, data_a}
                               : {data_a_eop, 1'b1, data_a, 8'h00};
  assign b_wr_data = {data_b_eop, data_b_eop & data_b_mty[0], data_b};
  assign c_wr_data = {data_c_eop, data_c_eop ? data_c_mty : 2'b00, data_c};

  fifo_p_arb_ch #(.DW(18), .AW(AW)) u_ch_a (
    .clk(clk), .rst(rst), .vld_i(data_a_vld), .sop_i(data_a_sop),
    .wr_req_i(a_wr_req), .wr_eop_i(data_a_eop), .wr_data_i(a_wr_data),
    .rd_en_i(rd_en[0]), .pkt_done_i(done[0]), .rd_data_o(ent_a), .pkt_avail_o(elig[0]));

  fifo_p_arb_ch #(.DW(18), .AW(AW)) u_ch_b (
    .clk(clk), .rst(rst), .vld_i(data_b_vld), .sop_i(data_b_sop),
    .wr_req_i(1'b1), .wr_eop_i(data_b_eop), .wr_data_i(b_wr_data),
    .rd_en_i(rd_en[1]), .pkt_done_i(done[1]), .rd_data_o(ent_b), .pkt_avail_o(elig[1]));

  fifo_p_arb_ch #(.DW(35), .AW(AW)) u_ch_c (
    .clk(clk), .rst(rst), .vld_i(data_c_vld), .sop_i(data_c_sop),
    .wr_req_i(1'b1), .wr_eop_i(data_c_eop), .wr_data_i(c_wr_data),
    .rd_en_i(rd_en[2]), .pkt_done_i(done[2]), .rd_data_o(ent_c), .pkt_avail_o(elig[2]));

  always_comb begin
    send     = (state_q == S_SEND);
    sel_word = '0;
    sel_eop  = 1'b0;
    sel_mty  = 1'b0;
    rd_en    = '0;
    half_d   = half_q;
    if (send) begin
      case (grant_q)
        2'd0: begin
          sel_word = ent_a[15:0];
          sel_eop  = ent_a[17];
          sel_mty  = ent_a[16];
          rd_en[0] = 1'b1;
        end
        2'd1: begin
          sel_word = ent_b[15:0];
          sel_eop  = ent_b[17];
          sel_mty  = ent_b[16];
          rd_en[1] = 1'b1;
        end
        default: begin
          // Upper half first; an eop entry with mty>=2 has no lower half to send.
          if (!half_q) begin
            sel_word = ent_c[31:16];
            if (ent_c[34] && ent_c[33]) begin
              sel_eop  = 1'b1;
              sel_mty  = ent_c[32];
              rd_en[2] = 1'b1;
            end else begin
              half_d = 1'b1;
            end
          end else begin
            sel_word = ent_c[15:0];
            sel_eop  = ent_c[34];
            sel_mty  = ent_c[34] & ent_c[32];
            rd_en[2] = 1'b1;
            half_d   = 1'b0;
          end
        end
      endcase
    end
    pkt_end = send & sel_eop;
    done    = pkt_end ? (3'b001 << grant_q) : 3'b000;
  end

`ifdef FIFO_P_RR_EN
  logic [1:0] rr_q, rr_d;

  always_comb begin
    case (rr_q)
      2'd1:    pick = elig[1] ? 2'd1 : (elig[2] ? 2'd2 : 2'd0);
      2'd2:    pick = elig[2] ? 2'd2 : (elig[0] ? 2'd0 : 2'd1);
      default: pick = elig[0] ? 2'd0 : (elig[1] ? 2'd1 : 2'd2);
    endcase
    rr_d = rr_q;
    if (free && (|elig)) rr_d = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= 2'd0;
    else     rr_q <= rr_d;
  end
`else
  always_comb begin
    pick = elig[0] ? 2'd0 : (elig[1] ? 2'd1 : 2'd2);
  end
`endif

  // Grants happen when idle or on the cycle the current eop word goes out.
  always_comb begin
    free    = ~send | pkt_end;
    state_d = state_q;
    grant_d = grant_q;
    first_d = send ? 1'b0 : first_q;
    if (free) begin
      if (|elig) begin
        state_d = S_SEND;
        grant_d = pick;
        first_d = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= 2'd0;
      half_q     <= 1'b0;
      first_q    <= 1'b0;
      a_odd_q    <= 1'b0;
      a_hold_q   <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_mty_q  <= 1'b0;
      out_chan_q <= 2'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      half_q  <= half_d;
      first_q <= first_d;
      if (data_a_vld) begin
        a_odd_q  <= a_odd_d;
        a_hold_q <= data_a;
      end
      out_data_q <= sel_word;
      out_vld_q  <= send;
      out_sop_q  <= send & first_q;
      out_eop_q  <= pkt_end;
      out_mty_q  <= sel_mty;
      out_chan_q <= send ? grant_q : 2'd0;
    end
  end

  assign data_d     = out_data_q;
  assign data_d_vld = out_vld_q;
  assign data_d_sop = out_sop_q;
  assign data_d_eop = out_eop_q;
  assign data_d_mty = out_mty_q;
  assign chan_d     = out_chan_q;
endmodule

// File: tb/tb_fifo_p_arb.sv
// tb_fifo_p_arb: directed bench for fifo_p_arb; expected words are built from the packet
// contents the bench drives, and output words are collected on the falling edge.
`timescale 1ns/1ps
module tb_fifo_p_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_a = '0;
  logic        data_a_vld = 1'b0, data_a_sop = 1'b0, data_a_eop = 1'b0;
  logic [15:0] data_b = '0;
  logic        data_b_vld = 1'b0, data_b_sop = 1'b0, data_b_eop = 1'b0;
  logic [1:0]  data_b_mty = '0;
  logic [31:0] data_c = '0;
  logic        data_c_vld = 1'b0, data_c_sop = 1'b0, data_c_eop = 1'b0;
  logic [1:0]  data_c_mty = '0;
  logic [15:0] data_d;
  logic        data_d_vld, data_d_sop, data_d_eop, data_d_mty;
  logic [1:0]  chan_d;

  always #5 clk = ~clk;

  fifo_p_arb #(.AW(6)) dut (
    .clk(clk), .rst(rst),
    .data_a(data_a), .data_a_vld(data_a_vld), .data_a_sop(data_a_sop), .data_a_eop(data_a_eop),
    .data_b(data_b), .data_b_vld(data_b_vld), .data_b_sop(data_b_sop), .data_b_eop(data_b_eop),
    .data_b_mty(data_b_mty),
    .data_c(data_c), .data_c_vld(data_c_vld), .data_c_sop(data_c_sop), .data_c_eop(data_c_eop),
    .data_c_mty(data_c_mty),
    .data_d(data_d), .data_d_vld(data_d_vld), .data_d_sop(data_d_sop), .data_d_eop(data_d_eop),
    .data_d_mty(data_d_mty), .chan_d(chan_d));

  typedef struct {
    logic [15:0] d;
    logic        sop;
    logic        eop;
    logic        mty;
    logic [1:0]  ch;
    int          cyc;
  } wd_t;

  wd_t got[$];
  wd_t exp_q[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  int  n_acc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_d_vld === 1'b1)
      got.push_back('{d: data_d, sop: data_d_sop, eop: data_d_eop, mty: data_d_mty, ch: chan_d, cyc: cyc});
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] d, input logic sop, input logic eop,
                          input logic mty, input logic [1:0] ch);
    wd_t w;
    w.d = d; w.sop = sop; w.eop = eop; w.mty = mty; w.ch = ch; w.cyc = 0;
    exp_q.push_back(w);
  endtask

  function automatic logic [31:0] pk(input wd_t w);
    return {11'd0, w.ch, w.sop, w.eop, w.mty, w.d};
  endfunction

  task automatic wait_out();
    int n = 0;
    while (got.size() < exp_q.size() && n < 3000) begin
      step();
      n++;
    end
    repeat (20) step();
  endtask

  task automatic compare(input string tag);
    check_eq({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check_eq($sformatf("%s_w%0d", tag, i), pk(got[i]), pk(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic send_a(input int n);
    logic [7:0] b[$];
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    for (int i = 0; i < n; i += 2) begin
      if (i + 1 < n) push_exp({b[i], b[i+1]}, i == 0, i + 2 >= n, 1'b0, 2'd0);
      else           push_exp({b[i], 8'h00},  i == 0, 1'b1,       1'b1, 2'd0);
    end
    for (int i = 0; i < n; i++) begin
      data_a = b[i]; data_a_vld = 1'b1; data_a_sop = (i == 0); data_a_eop = (i == n - 1);
      step();
    end
    data_a_vld = 1'b0; data_a_sop = 1'b0; data_a_eop = 1'b0;
  endtask

  task automatic send_b(input int n, input logic [1:0] mty, input bit expect_out);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      if (expect_out) push_exp(w, i == 0, i == n - 1, (i == n - 1) & mty[0], 2'd1);
      data_b = w; data_b_vld = 1'b1; data_b_sop = (i == 0); data_b_eop = (i == n - 1);
      data_b_mty = (i == n - 1) ? mty : 2'd0;
      step();
    end
    data_b_vld = 1'b0; data_b_sop = 1'b0; data_b_eop = 1'b0; data_b_mty = 2'd0;
  endtask

  task automatic send_c(input int n, input logic [1:0] mty);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (i < n - 1) begin
        push_exp(w[31:16], i == 0, 1'b0, 1'b0, 2'd2);
        push_exp(w[15:0],  1'b0,   1'b0, 1'b0, 2'd2);
      end else if (mty >= 2'd2) begin
        push_exp(w[31:16], i == 0, 1'b1, mty == 2'd3, 2'd2);
      end else begin
        push_exp(w[31:16], i == 0, 1'b0, 1'b0, 2'd2);
        push_exp(w[15:0],  1'b0,   1'b1, mty[0], 2'd2);
      end
      data_c = w; data_c_vld = 1'b1; data_c_sop = (i == 0); data_c_eop = (i == n - 1);
      data_c_mty = (i == n - 1) ? mty : 2'd0;
      step();
    end
    data_c_vld = 1'b0; data_c_sop = 1'b0; data_c_eop = 1'b0; data_c_mty = 2'd0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check_eq("rst_vld", {31'd0, data_d_vld}, 32'd0);
    check_eq("rst_out", {11'd0, chan_d, data_d_sop, data_d_eop, data_d_mty, data_d}, 32'd0);
    rst = 1'b0;
    step();

    send_a(32); wait_out(); compare("a32");
    send_a(33); wait_out(); compare("a33");
    send_b(32, 2'd1, 1'b1); wait_out(); compare("b32");
    send_c(32, 2'd1); wait_out(); compare("c32m1");
    send_c(32, 2'd2); wait_out(); compare("c32m2");
    send_c(32, 2'd3); wait_out(); compare("c32m3");

    // Single-beat packets on all three channels in the same cycle.
    data_a = 8'h5A; data_a_vld = 1'b1; data_a_sop = 1'b1; data_a_eop = 1'b1;
    data_b = 16'h1234; data_b_vld = 1'b1; data_b_sop = 1'b1; data_b_eop = 1'b1; data_b_mty = 2'd0;
    data_c = 32'hCAFEF00D; data_c_vld = 1'b1; data_c_sop = 1'b1; data_c_eop = 1'b1; data_c_mty = 2'd0;
    step();
    n_acc = cyc;
    data_a_vld = 1'b0; data_a_sop = 1'b0; data_a_eop = 1'b0;
    data_b_vld = 1'b0; data_b_sop = 1'b0; data_b_eop = 1'b0;
    data_c_vld = 1'b0; data_c_sop = 1'b0; data_c_eop = 1'b0;
    push_exp(16'h5A00, 1'b1, 1'b1, 1'b1, 2'd0);
    push_exp(16'h1234, 1'b1, 1'b1, 1'b0, 2'd1);
    push_exp(16'hCAFE, 1'b1, 1'b0, 1'b0, 2'd2);
    push_exp(16'hF00D, 1'b0, 1'b1, 1'b0, 2'd2);
    wait_out();
    if (got.size() > 0) check_eq("abc_latency", 32'(got[0].cyc), 32'(n_acc + 2));
    for (int i = 1; i < got.size(); i++)
      check_eq($sformatf("abc_gap%0d", i), 32'(got[i].cyc - got[0].cyc), 32'(i));
    compare("abc");

    // A and C become eligible while B is being sent.
    send_b(8, 2'd0, 1'b1);
    data_a = 8'h11; data_a_vld = 1'b1; data_a_sop = 1'b1; data_a_eop = 1'b1;
    data_c = 32'h01020304; data_c_vld = 1'b1; data_c_sop = 1'b1; data_c_eop = 1'b1; data_c_mty = 2'd3;
    step();
    data_a_vld = 1'b0; data_a_sop = 1'b0; data_a_eop = 1'b0;
    data_c_vld = 1'b0; data_c_sop = 1'b0; data_c_eop = 1'b0; data_c_mty = 2'd0;
`ifdef FIFO_P_RR_EN
    push_exp(16'h0102, 1'b1, 1'b1, 1'b1, 2'd2);
    push_exp(16'h1100, 1'b1, 1'b1, 1'b1, 2'd0);
`else
    push_exp(16'h1100, 1'b1, 1'b1, 1'b1, 2'd0);
    push_exp(16'h0102, 1'b1, 1'b1, 1'b1, 2'd2);
`endif
    wait_out(); compare("prio");

    // 65 words cannot fit in 64 entries; the following short packet must survive.
    send_b(65, 2'd0, 1'b0);
    send_b(4, 2'd1, 1'b1);
    wait_out(); compare("ovf");

    // A new sop inside an open packet discards the partial packet.
    for (int i = 0; i < 3; i++) begin
      data_b = 16'hDEAD; data_b_vld = 1'b1; data_b_sop = (i == 0); data_b_eop = 1'b0;
      step();
    end
    send_b(2, 2'd0, 1'b1);
    wait_out(); compare("rewind");

    // Reset in the middle of a C packet; its tail (no sop) must be discarded.
    for (int i = 0; i < 3; i++) begin
      data_c = 32'h77777777; data_c_vld = 1'b1; data_c_sop = (i == 0); data_c_eop = 1'b0;
      step();
    end
    data_c_vld = 1'b0; data_c_sop = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_vld", {31'd0, data_d_vld}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      data_c = 32'h88888888; data_c_vld = 1'b1; data_c_sop = 1'b0; data_c_eop = (i == 1);
      step();
    end
    data_c_vld = 1'b0; data_c_eop = 1'b0;
    data_b = 16'hBEEF; data_b_vld = 1'b1; data_b_sop = 1'b1; data_b_eop = 1'b1; data_b_mty = 2'd1;
    data_c = 32'hAABBCCDD; data_c_vld = 1'b1; data_c_sop = 1'b1; data_c_eop = 1'b1; data_c_mty = 2'd2;
    step();
    data_b_vld = 1'b0; data_b_sop = 1'b0; data_b_eop = 1'b0; data_b_mty = 2'd0;
    data_c_vld = 1'b0; data_c_sop = 1'b0; data_c_eop = 1'b0; data_c_mty = 2'd0;
    push_exp(16'hBEEF, 1'b1, 1'b1, 1'b1, 2'd1);
    push_exp(16'hAABB, 1'b1, 1'b1, 1'b0, 2'd2);
    wait_out(); compare("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
